ascon_ctrl_fsm: RTL and testbench
=================================

# ascon_ctrl_fsm

Control sequencer for the ASCON-128 encryption datapath, sitting directly upstream of the permutation stage (state register, round function, data/key XOR, cipher output). It counts rounds and emits, cycle by cycle, the permutation stage's controls: state-register enable, input/feedback select, round index and XOR strobes. It also exchanges a valid/ready handshake with the block-data source and flags cipher, tag and completion events.

## Interface
Parameters:
- NB_PT_BLOCKS, 4: number of 64-bit plaintext blocks per message; legal 1..15; the last one is absorbed in finalization.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clock_i  in  1  system clock.
- resetb_i  in  1  asynchronous active-low reset.
- start_i  in  1  start one encryption; sampled only in IDLE.
- data_valid_i  in  1  AD/plaintext block present on the datapath input.
- data_ready_o  out  1  high in every WAIT state; a block is accepted when data_valid_i && data_ready_o.
- round_o  out  4  round index to the permutation.
- selectionp_o  out  1  0 = load external initial state, 1 = feed back state register.
- enable_o  out  1  permutation state-register enable.
- en_xor_data_o  out  1  XOR input data into x0 at this round.
- en_xor_key_begin_o  out  1  XOR key into x1..x2 before the round.
- en_xor_key_end_o  out  1  XOR key into x3..x4 after the round.
- en_xor_lsb_o  out  1  domain-separation XOR of 1 into x4 LSB after the round.
- en_cipher_o  out  1  capture C at this edge.
- en_tag_o  out  1  capture tag at this edge.
- cipher_valid_o  out  1  one-cycle pulse, cycle after en_cipher_o.
- tag_valid_o  out  1  one-cycle pulse, cycle after en_tag_o.
- done_o  out  1  one-cycle completion pulse.

## Operation
- Reset value of every output: 0; state IDLE; round counter 0; block counter 0.
- Each cycle with enable_o=1 executes exactly one round, numbered round_o.
- Round counter:
  - p12 loads 0 and counts 0..11.
  - p6 loads 6 and counts 6..11.
- States and transitions:
  - IDLE: all outputs 0. start_i -> INIT.
  - INIT (12 cycles, rounds 0..11): enable_o=1. selectionp_o=0 on round 0, then 1. en_xor_key_end_o=1 on round 11. Next: AD_WAIT.
  - AD_WAIT: enable_o=0, data_ready_o=1. Accept -> AD_RUN.
  - AD_RUN (6 cycles, rounds 6..11): en_xor_data_o on round 6, en_xor_lsb_o on round 11. Next: PT_WAIT, or FIN_WAIT if NB_PT_BLOCKS=1.
  - PT_WAIT: as AD_WAIT. Accept -> PT_RUN.
  - PT_RUN (rounds 6..11): en_xor_data_o and en_cipher_o on round 6. Block counter +1 at exit. Next: PT_WAIT while counter < NB_PT_BLOCKS-1, else FIN_WAIT.
  - FIN_WAIT: as AD_WAIT. Accept -> FIN_RUN.
  - FIN_RUN (12 cycles, rounds 0..11):
    - Round 0: en_xor_data_o, en_cipher_o, en_xor_key_begin_o.
    - Round 11: en_xor_key_end_o, en_tag_o.
  - END: done_o=1 for one cycle; block counter cleared. Next: IDLE.
- Boundary conditions:
  - start_i outside IDLE: ignored.
  - data_valid_i outside WAIT states: ignored, not queued.
  - data_valid_i held high: each WAIT state still lasts exactly one cycle.
  - resetb_i low at any time: immediate return to the reset values; an in-flight message is abandoned.
  - Round counter at 11 wraps only through a load; it never free-runs past 11.

## Timing
- Cycle 1 = first cycle after the edge that samples start_i; data_valid_i held high throughout.
- NB_PT_BLOCKS=4:
  - INIT 1–12, AD_WAIT 13, AD_RUN 14–19.
  - PT blocks at 20–26, 27–33 and 34–40, each one WAIT cycle plus 6 RUN cycles.
  - FIN_WAIT 41, FIN_RUN 42–53.
  - done_o in cycle 54.
- General latency: 12 + 7 + 7·(NB_PT_BLOCKS−1) + 13 + 1 cycles, plus any extra cycles spent waiting for data.
- cipher_valid_o in cycles 22, 29, 36, 43. tag_valid_o in cycle 54, coincident with done_o.

## Configuration
- ASCON_AD_EN defined: AD_WAIT/AD_RUN are present as described.
- ASCON_AD_EN undefined:
  - INIT goes straight to PT_WAIT (or to FIN_WAIT if NB_PT_BLOCKS=1).
  - en_xor_lsb_o is asserted together with en_xor_key_end_o on INIT round 11.
  - Latency is 7 cycles shorter; done_o in cycle 47 for NB_PT_BLOCKS=4.

## Structure
- Shared package ascon_pack holds:
  - enum type_fsm_state.
  - Constants ROUND_P12_START=4'd0, ROUND_P6_START=4'd6, ROUND_LAST=4'd11.
- One sub-module, round_counter: async active-low reset; load-to-0 and load-to-6 inputs; count enable; 4-bit output.
- The FSM instantiates it and holds the block counter locally.

## Test plan
- Reset: resetb_i=0 for 25 ns, then start_i=1 in cycle 0 with data_valid_i=1 held -> done_o only in cycle 54; round_o sequence 0..11, 6..11 ×4, 0..11.
- INIT strobes: selectionp_o=0 only in cycle 1; en_xor_key_end_o only in cycle 12.
- Data stall: data_valid_i=0 until cycle 30 -> FSM stays in AD_WAIT with enable_o=0 and data_ready_o=1; AD_RUN starts in cycle 31; done_o in cycle 71.
- Spurious inputs: start_i pulsed in cycle 5 and data_valid_i toggled during RUN states -> no change in sequence or latency.
- Mid-message reset: resetb_i low in cycle 25 -> all outputs 0 asynchronously; a new start after release gives done_o exactly 54 cycles later.
- NB_PT_BLOCKS=1 with ASCON_AD_EN undefined: en_xor_lsb_o and en_xor_key_end_o both high in cycle 12; FIN_WAIT in cycle 13; done_o in cycle 26.

Source files
------------

// File: rtl/ascon_ctrl_fsm_pkg.sv
// Shared types and constants for the ASCON-128 control sequencer.
// Holds the FSM state enum, the round-counter start/stop values and the
// single next-round rule used by both the counter and the FSM output stage.
package ascon_pack;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_INIT     = 4'd1,
        ST_AD_WAIT  = 4'd2,
        ST_AD_RUN   = 4'd3,
        ST_PT_WAIT  = 4'd4,
        ST_PT_RUN   = 4'd5,
        ST_FIN_WAIT = 4'd6,
        ST_FIN_RUN  = 4'd7,
        ST_END      = 4'd8
    } type_fsm_state;

    localparam logic [3:0] ROUND_P12_START = 4'd0;
    localparam logic [3:0] ROUND_P6_START  = 4'd6;
    localparam logic [3:0] ROUND_LAST      = 4'd11;

    // Loads win over counting; counting saturates at the last round so the
    // index can only leave 11 through an explicit load.
    function automatic logic [3:0] next_round(
        input logic [3:0] cur,
        input logic       load_p12,
        input logic       load_p6,
        input logic       count_en
    );
        logic [3:0] nxt;
        nxt = cur;
        if (load_p12) begin
            nxt = ROUND_P12_START;
        end else if (load_p6) begin
            nxt = ROUND_P6_START;
        end else if (count_en && (cur != ROUND_LAST)) begin
            nxt = cur + 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ascon_ctrl_fsm_round_counter.sv
// Round index counter for the ASCON permutation sequencer.
// p12 loads 0, p6 loads 6, then counts up to 11 and holds there.
import ascon_pack::*;

module round_counter (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       load_p12_i,
    input  logic       load_p6_i,
    input  logic       count_en_i,
    output logic [3:0] round_o
);

    logic [3:0] round_q;
    logic [3:0] round_d;

    // Next round index from the load/count controls.
    always_comb begin
        round_d = next_round(round_q, load_p12_i, load_p6_i, count_en_i);
    end

    // Round index register.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            round_q <= 4'd0;
        end else begin
            round_q <= round_d;
        end
    end

    assign round_o = round_q;

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// ASCON-128 encryption control sequencer.
// Walks INIT -> (AD) -> PT blocks -> FIN -> END and drives the permutation
// stage controls one round per cycle. All outputs are registered: they are
// decoded from the next state and next round index so that they line up with
// the cycle in which that state/round is current.
// Build option: define ASCON_AD_EN to include the associated-data phase
// (AD_WAIT/AD_RUN); without it INIT goes straight to the plaintext phase and
// the domain-separation bit is applied on INIT round 11.
import ascon_pack::*;

module ascon_ctrl_fsm #(
    parameter int NB_PT_BLOCKS = 4
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       data_valid_i,
    output logic       data_ready_o,
    output logic [3:0] round_o,
    output logic       selectionp_o,
    output logic       enable_o,
    output logic       en_xor_data_o,
    output logic       en_xor_key_begin_o,
    output logic       en_xor_key_end_o,
    output logic       en_xor_lsb_o,
    output logic       en_cipher_o,
    output logic       en_tag_o,
    output logic       cipher_valid_o,
    output logic       tag_valid_o,
    output logic       done_o
);

    // Index of the last plaintext block that goes through PT_RUN; the final
    // block is absorbed in FIN_RUN instead.
    localparam logic [3:0] LAST_PT_IDX = 4'(NB_PT_BLOCKS - 1);

    // Handshake: a block is taken in the cycle where data_valid_i and
    // data_ready_o are both high; data_ready_o is high exactly in WAIT states,
    // so every accepted WAIT lasts one cycle and nothing is queued elsewhere.

    type_fsm_state state_q, state_d;
    logic [3:0]    blk_q, blk_d;
    logic [3:0]    round_q;
    logic [3:0]    round_nxt;
    logic          load_p12;
    logic          load_p6;
    logic          count_en;
    logic          accept;
    logic          last_round;
    type_fsm_state after_init;
    type_fsm_state after_ad;

    logic          data_ready_q, data_ready_d;
    logic [3:0]    round_o_q, round_o_d;
    logic          selectionp_q, selectionp_d;
    logic          enable_q, enable_d;
    logic          xor_data_q, xor_data_d;
    logic          key_begin_q, key_begin_d;
    logic          key_end_q, key_end_d;
    logic          xor_lsb_q, xor_lsb_d;
    logic          cipher_q, cipher_d;
    logic          tag_q, tag_d;
    logic          cipher_valid_q, cipher_valid_d;
    logic          tag_valid_q, tag_valid_d;
    logic          done_q, done_d;

    round_counter u_round_counter (
        .clock_i    (clock_i),
        .resetb_i   (resetb_i),
        .load_p12_i (load_p12),
        .load_p6_i  (load_p6),
        .count_en_i (count_en),
        .round_o    (round_q)
    );

    assign accept     = data_valid_i && data_ready_q;
    assign last_round = (round_q == ROUND_LAST);
    assign after_ad   = (NB_PT_BLOCKS == 1) ? ST_FIN_WAIT : ST_PT_WAIT;
`ifdef ASCON_AD_EN
    assign after_init = ST_AD_WAIT;
`else
    assign after_init = after_ad;
`endif

    // Next state, block counter and round-counter controls.
    always_comb begin
        state_d  = state_q;
        blk_d    = blk_q;
        load_p12 = 1'b0;
        load_p6  = 1'b0;
        count_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_INIT;
                    load_p12 = 1'b1;
                end
            end
            ST_INIT: begin
                if (last_round) state_d = after_init;
                else            count_en = 1'b1;
            end
            ST_AD_WAIT: begin
                if (accept) begin
                    state_d = ST_AD_RUN;
                    load_p6 = 1'b1;
                end
            end
            ST_AD_RUN: begin
                if (last_round) state_d = after_ad;
                else            count_en = 1'b1;
            end
            ST_PT_WAIT: begin
                if (accept) begin
                    state_d = ST_PT_RUN;
                    load_p6 = 1'b1;
                end
            end
            ST_PT_RUN: begin
                if (last_round) begin
                    blk_d   = blk_q + 4'd1;
                    state_d = (blk_d < LAST_PT_IDX) ? ST_PT_WAIT : ST_FIN_WAIT;
                end else begin
                    count_en = 1'b1;
                end
            end
            ST_FIN_WAIT: begin
                if (accept) begin
                    state_d  = ST_FIN_RUN;
                    load_p12 = 1'b1;
                end
            end
            ST_FIN_RUN: begin
                if (last_round) state_d = ST_END;
                else            count_en = 1'b1;
            end
            ST_END: begin
                // Rewind the round counter too, so IDLE shows round 0.
                blk_d    = 4'd0;
                load_p12 = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                blk_d   = 4'd0;
            end
        endcase
        round_nxt = next_round(round_q, load_p12, load_p6, count_en);
    end

    // Output decode for the state/round that becomes current at the next edge.
    always_comb begin
        logic run_p12_first;
        logic run_last;
        round_o_d      = round_nxt;
        data_ready_d   = 1'b0;
        selectionp_d   = 1'b0;
        enable_d       = 1'b0;
        xor_data_d     = 1'b0;
        key_begin_d    = 1'b0;
        key_end_d      = 1'b0;
        xor_lsb_d      = 1'b0;
        cipher_d       = 1'b0;
        tag_d          = 1'b0;
        done_d         = 1'b0;
        cipher_valid_d = cipher_q;
        tag_valid_d    = tag_q;
        run_p12_first  = (round_nxt == ROUND_P12_START);
        run_last       = (round_nxt == ROUND_LAST);
        if (state_d != ST_IDLE) begin
            selectionp_d = 1'b1;
        end
        case (state_d)
            ST_INIT: begin
                enable_d     = 1'b1;
                selectionp_d = !run_p12_first;
                key_end_d    = run_last;
`ifndef ASCON_AD_EN
                xor_lsb_d    = run_last;
`endif
            end
            ST_AD_RUN: begin
                enable_d   = 1'b1;
                xor_data_d = (round_nxt == ROUND_P6_START);
                xor_lsb_d  = run_last;
            end
            ST_PT_RUN: begin
                enable_d   = 1'b1;
                xor_data_d = (round_nxt == ROUND_P6_START);
                cipher_d   = (round_nxt == ROUND_P6_START);
            end
            ST_FIN_RUN: begin
                enable_d    = 1'b1;
                xor_data_d  = run_p12_first;
                cipher_d    = run_p12_first;
                key_begin_d = run_p12_first;
                key_end_d   = run_last;
                tag_d       = run_last;
            end
            ST_AD_WAIT, ST_PT_WAIT, ST_FIN_WAIT: begin
                data_ready_d = 1'b1;
            end
            ST_END: begin
                done_d = 1'b1;
            end
            default: begin
                round_o_d = 4'd0;
            end
        endcase
    end

    // State, block counter and registered outputs.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q        <= ST_IDLE;
            blk_q          <= 4'd0;
            data_ready_q   <= 1'b0;
            round_o_q      <= 4'd0;
            selectionp_q   <= 1'b0;
            enable_q       <= 1'b0;
            xor_data_q     <= 1'b0;
            key_begin_q    <= 1'b0;
            key_end_q      <= 1'b0;
            xor_lsb_q      <= 1'b0;
            cipher_q       <= 1'b0;
            tag_q          <= 1'b0;
            cipher_valid_q <= 1'b0;
            tag_valid_q    <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            blk_q          <= blk_d;
            data_ready_q   <= data_ready_d;
            round_o_q      <= round_o_d;
            selectionp_q   <= selectionp_d;
            enable_q       <= enable_d;
            xor_data_q     <= xor_data_d;
            key_begin_q    <= key_begin_d;
            key_end_q      <= key_end_d;
            xor_lsb_q      <= xor_lsb_d;
            cipher_q       <= cipher_d;
            tag_q          <= tag_d;
            cipher_valid_q <= cipher_valid_d;
            tag_valid_q    <= tag_valid_d;
            done_q         <= done_d;
        end
    end

    assign data_ready_o       = data_ready_q;
    assign round_o            = round_o_q;
    assign selectionp_o       = selectionp_q;
    assign enable_o           = enable_q;
    assign en_xor_data_o      = xor_data_q;
    assign en_xor_key_begin_o = key_begin_q;
    assign en_xor_key_end_o   = key_end_q;
    assign en_xor_lsb_o       = xor_lsb_q;
    assign en_cipher_o        = cipher_q;
    assign en_tag_o           = tag_q;
    assign cipher_valid_o     = cipher_valid_q;
    assign tag_valid_o        = tag_valid_q;
    assign done_o             = done_q;

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Self-checking bench for ascon_ctrl_fsm.
// A phase-level model (INIT / WAIT / RUN / END with per-phase stall counts)
// expands each message into per-cycle expected outputs pushed on a queue;
// a monitor pops one entry per cycle and compares, and separately checks the
// done_o cycle against a closed-form latency.
module tb_ascon_ctrl_fsm;

    localparam int NB = 4;
`ifdef ASCON_AD_EN
    localparam bit AD_EN = 1'b1;
`else
    localparam bit AD_EN = 1'b0;
`endif

    localparam int K_INIT = 0;
    localparam int K_AD   = 1;
    localparam int K_PT   = 2;
    localparam int K_FIN  = 3;

    // Bit positions in the packed output vector.
    localparam int B_DONE = 0;
    localparam int B_TVAL = 1;
    localparam int B_CVAL = 2;
    localparam int B_TAG  = 3;
    localparam int B_CIPH = 4;
    localparam int B_LSB  = 5;
    localparam int B_KEND = 6;
    localparam int B_KBEG = 7;
    localparam int B_XD   = 8;
    localparam int B_EN   = 9;
    localparam int B_SEL  = 10;
    localparam int B_RDY  = 11;
    localparam logic [15:0] MSK_ALL     = 16'hFFFF;
    localparam logic [15:0] MSK_NOROUND = 16'h0BFF;

    logic       clock_i = 1'b1;
    logic       resetb_i = 1'b0;
    logic       start_i = 1'b0;
    logic       data_valid_i = 1'b0;
    logic       data_ready_o;
    logic [3:0] round_o;
    logic       selectionp_o;
    logic       enable_o;
    logic       en_xor_data_o;
    logic       en_xor_key_begin_o;
    logic       en_xor_key_end_o;
    logic       en_xor_lsb_o;
    logic       en_cipher_o;
    logic       en_tag_o;
    logic       cipher_valid_o;
    logic       tag_valid_o;
    logic       done_o;

    // ---------------- clock / reset ----------------
    always #5 clock_i = ~clock_i;

    ascon_ctrl_fsm #(.NB_PT_BLOCKS(NB)) dut (
        .clock_i            (clock_i),
        .resetb_i           (resetb_i),
        .start_i            (start_i),
        .data_valid_i       (data_valid_i),
        .data_ready_o       (data_ready_o),
        .round_o            (round_o),
        .selectionp_o       (selectionp_o),
        .enable_o           (enable_o),
        .en_xor_data_o      (en_xor_data_o),
        .en_xor_key_begin_o (en_xor_key_begin_o),
        .en_xor_key_end_o   (en_xor_key_end_o),
        .en_xor_lsb_o       (en_xor_lsb_o),
        .en_cipher_o        (en_cipher_o),
        .en_tag_o           (en_tag_o),
        .cipher_valid_o     (cipher_valid_o),
        .tag_valid_o        (tag_valid_o),
        .done_o             (done_o)
    );

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic [15:0] exp_q[$];
    logic [15:0] msk_q[$];
    int          lat_q[$];
    logic [15:0] gv[$];
    logic [15:0] gm[$];
    bit          gdv[$];
    int          stall[16];

    function automatic logic [15:0] act_vec();
        return {round_o, data_ready_o, selectionp_o, enable_o, en_xor_data_o,
                en_xor_key_begin_o, en_xor_key_end_o, en_xor_lsb_o, en_cipher_o,
                en_tag_o, cipher_valid_o, tag_valid_o, done_o};
    endfunction

    // ---------------- reference model ----------------
    task automatic add_run(input int kind, input int first, input int last);
        for (int r = first; r <= last; r++) begin
            logic [15:0] v;
            v = '0;
            v[15:12] = 4'(r);
            v[B_EN]  = 1'b1;
            v[B_SEL] = !(kind == K_INIT && r == 0);
            v[B_XD]  = ((kind == K_AD || kind == K_PT) && r == 6) || (kind == K_FIN && r == 0);
            v[B_KBEG] = (kind == K_FIN && r == 0);
            v[B_KEND] = (kind == K_INIT || kind == K_FIN) && r == 11;
            v[B_LSB]  = (kind == K_AD && r == 11) || (!AD_EN && kind == K_INIT && r == 11);
            v[B_CIPH] = (kind == K_PT && r == 6) || (kind == K_FIN && r == 0);
            v[B_TAG]  = (kind == K_FIN && r == 11);
            gv.push_back(v);
            gm.push_back(MSK_ALL);
            gdv.push_back(1'($urandom_range(0, 1)));
        end
    endtask

    task automatic add_wait(input int k);
        logic [15:0] v;
        v = '0;
        v[B_RDY] = 1'b1;
        for (int i = 0; i <= k; i++) begin
            gv.push_back(v);
            gm.push_back(MSK_NOROUND);
            gdv.push_back(i == k);
        end
    endtask

    task automatic add_simple(input logic [15:0] v, input logic [15:0] m);
        gv.push_back(v);
        gm.push_back(m);
        gdv.push_back(1'($urandom_range(0, 1)));
    endtask

    // Expands one message into per-cycle expectations for cycles 1..N+2.
    task automatic build_msg(input bit hold_dv);
        logic [15:0] t;
        gv.delete(); gm.delete(); gdv.delete();
        add_run(K_INIT, 0, 11);
        if (AD_EN) begin
            add_wait(stall[0]);
            add_run(K_AD, 6, 11);
        end
        for (int b = 1; b < NB; b++) begin
            add_wait(stall[b]);
            add_run(K_PT, 6, 11);
        end
        add_wait(stall[15]);
        add_run(K_FIN, 0, 11);
        add_simple(16'h0001, MSK_NOROUND);
        add_simple(16'h0000, MSK_ALL);
        add_simple(16'h0000, MSK_ALL);
        // Valid pulses follow their capture strobes by one cycle.
        for (int i = gv.size() - 1; i >= 1; i--) begin
            t = gv[i];
            t[B_CVAL] = gv[i-1][B_CIPH];
            t[B_TVAL] = gv[i-1][B_TAG];
            gv[i] = t;
        end
        if (hold_dv) begin
            for (int i = 0; i < gdv.size(); i++) gdv[i] = 1'b1;
        end
    endtask

    function automatic int exp_latency();
        int l;
        l = 12 + (AD_EN ? 7 : 0) + 7 * (NB - 1) + 13 + 1;
        if (AD_EN) l += stall[0];
        for (int b = 1; b < NB; b++) l += stall[b];
        l += stall[15];
        return l;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock_i);
            start_i = 1'b0;
            data_valid_i = 1'($urandom_range(0, 1));
            exp_q.push_back(16'h0000);
            msk_q.push_back(MSK_ALL);
        end
    endtask

    // abort_at = 0 runs the whole message; otherwise reset in that cycle.
    task automatic run_msg(input bit hold_dv, input int abort_at);
        int n;
        @(negedge clock_i);
        build_msg(hold_dv);
        n = gv.size();
        start_i = 1'b1;
        data_valid_i = hold_dv ? 1'b1 : 1'($urandom_range(0, 1));
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(gv[i]);
            msk_q.push_back(gm[i]);
        end
        if (abort_at == 0) lat_q.push_back(cyc + exp_latency());
        for (int c = 1; c < n; c++) begin
            if (abort_at != 0 && c == abort_at) break;
            @(negedge clock_i);
            start_i = (c < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            data_valid_i = gdv[c-1];
        end
        if (abort_at != 0) begin
            @(negedge clock_i);
            mon_en = 1'b0;
            #2 resetb_i = 1'b0;
            #1;
            checks++;
            if (act_vec() !== 16'h0000) begin
                failures++;
                $display("FAIL async_reset_outputs got=%h exp=0000", act_vec());
            end
            exp_q.delete(); msk_q.delete(); lat_q.delete();
            start_i = 1'b0;
            @(negedge clock_i);
            resetb_i = 1'b1;
            exp_q.push_back(16'h0000);
            msk_q.push_back(MSK_ALL);
            mon_en = 1'b1;
        end
    endtask

    function automatic void clear_stalls();
        for (int i = 0; i < 16; i++) stall[i] = 0;
    endfunction

    // ---------------- monitor ----------------
    always @(posedge clock_i) begin
        logic [15:0] e, m, a;
        int          ec;
        #1;
        cyc++;
        if (mon_en) begin
            a = act_vec();
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL queue_underflow cycle=%0d got=%h", cyc, a);
            end else begin
                e = exp_q.pop_front();
                m = msk_q.pop_front();
                if ((a & m) !== (e & m)) begin
                    failures++;
                    $display("FAIL cycle_outputs cycle=%0d got=%h exp=%h mask=%h", cyc, a, e, m);
                end
            end
            if (done_o === 1'b1) begin
                checks++;
                if (lat_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done cycle=%0d", cyc);
                end else begin
                    ec = lat_q.pop_front();
                    if (cyc != ec) begin
                        failures++;
                        $display("FAIL done_latency got_cycle=%0d exp_cycle=%0d", cyc, ec);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        clear_stalls();
        repeat (2) @(negedge clock_i);
        checks++;
        if (act_vec() !== 16'h0000) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0000", act_vec());
        end
        @(negedge clock_i);
        resetb_i = 1'b1;
        exp_q.push_back(16'h0000);
        msk_q.push_back(MSK_ALL);
        mon_en = 1'b1;
        idle(2);

        // Baseline with data_valid_i held high.
        run_msg(1'b1, 0);
        idle(3);

        // Long stall in the first WAIT state after INIT.
        clear_stalls();
        stall[AD_EN ? 0 : 1] = 17;
        run_msg(1'b0, 0);
        idle(2);

        // Reset in the middle of a message, then a clean restart.
        clear_stalls();
        run_msg(1'b0, 25);
        idle(1);
        run_msg(1'b1, 0);
        idle(2);

        // Random stalls and spurious inputs.
        for (int m = 0; m < 6; m++) begin
            for (int i = 0; i < 16; i++) stall[i] = $urandom_range(0, 4);
            run_msg(1'b0, 0);
            idle($urandom_range(0, 3));
        end

        idle(3);
        @(posedge clock_i);
        #2;
        checks++;
        if (lat_q.size() != 0) begin
            failures++;
            $display("FAIL missing_done pending=%0d exp=0", lat_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
